// File: rtl/ecc_encoder.sv
// -----------------------------------------------------------------------------
// ecc_encoder
//   Streams an 8-word x 16-bit page through with one cycle of latency and
//   computes an 8-bit page code as it goes. Bit p of the page is
//   bit (p % 16) of the word with index p / 16.
//     code[6:0] : XOR of (p + 1) over every set page bit p = 0..126
//                 (Hamming-style syndrome field).
//     code[7]   : page bit 127 (word 7, bit 15), carried directly.
//   Words must arrive in order 0..7. Index 8 marks an idle cycle (a gap) and
//   may appear anywhere. Word 0 always starts or restarts a page. Any other
//   out-of-order index is a sequence error: the partial page is dropped.
//
// Optional feature (define ECC_ERR_INJECT_EN at build time):
//   Single-bit error injection into the outgoing data for testing a
//   downstream decoder. The page code is still computed from clean data.
//   When undefined, inj_valid / inj_pos are accepted but ignored.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   rst        in   1   asynchronous active-high reset
//   in_batch   in   4   incoming word index 0..7, 8 = idle
//   in_data    in  16   incoming page word
//   inj_valid  in   1   error-injection request, sampled with word 0
//   inj_pos    in   7   page bit position to corrupt
//   out_batch  out  4   index of the word on out_data, 8 = idle
//   out_data   out 16   outgoing page word (held on idle cycles)
//   out_code   out  8   page code, valid when out_batch == 7, held otherwise
//   page_done  out  1   one-cycle pulse together with out_batch == 7
//   seq_err    out  1   one-cycle pulse after a sequence violation
// -----------------------------------------------------------------------------
module ecc_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  in_batch,
  input  logic [15:0] in_data,
  input  logic        inj_valid,
  input  logic [6:0]  inj_pos,
  output logic [3:0]  out_batch,
  output logic [15:0] out_data,
  output logic [7:0]  out_code,
  output logic        page_done,
  output logic        seq_err
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_ACTIVE  = 1'b1;
  localparam logic [3:0] BATCH_IDLE = 4'd8;

  // Contribution of one word to code[6:0]: XOR of (16*b + i + 1) over its
  // set bits. Bit 127 is excluded; it is carried in code[7] instead.
  function automatic logic [6:0] word_contrib(input logic [2:0]  b,
                                              input logic [15:0] w);
    logic [6:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      if (w[i] && !(b == 3'd7 && i == 15)) c ^= ({b, 4'(i)} + 7'd1);
    end
    return c;
  endfunction

  logic [0:0]  state_q, state_d;
  logic [2:0]  expected_q, expected_d;
  logic [6:0]  acc_q, acc_d;
  logic [3:0]  out_batch_q, out_batch_d;
  logic [15:0] out_data_q, out_data_d;
  logic [7:0]  out_code_q, out_code_d;
  logic        page_done_q, page_done_d;
  logic        seq_err_q, seq_err_d;

  logic        is_gap, is_start, accept, violation, page_end;
  logic [6:0]  contrib;
  logic [15:0] flip_mask;

  assign is_gap    = (in_batch == BATCH_IDLE);
  // Word 0 is legal in any state: it starts a page from IDLE and restarts
  // one from ACTIVE.
  assign is_start  = (in_batch == 4'd0);
  assign accept    = is_start ||
                     (!in_batch[3] && state_q == ST_ACTIVE &&
                      in_batch[2:0] == expected_q);
  assign violation = !accept && !is_gap;
  assign page_end  = accept && (in_batch == 4'd7);
  assign contrib   = word_contrib(in_batch[2:0], in_data);

`ifdef ECC_ERR_INJECT_EN
  logic       inj_en_q, inj_en_d;
  logic [6:0] inj_pos_q, inj_pos_d;
  logic       inj_en_now;
  logic [6:0] inj_pos_now;

  // Word 0 may itself be the injection target, so it uses the live request
  // rather than the latch it is about to load.
  assign inj_en_now  = is_start ? inj_valid : inj_en_q;
  assign inj_pos_now = is_start ? inj_pos   : inj_pos_q;
  assign flip_mask   = (accept && inj_en_now &&
                        inj_pos_now[6:4] == in_batch[2:0])
                       ? (16'd1 << inj_pos_now[3:0]) : 16'd0;

  always_comb begin
    inj_en_d  = inj_en_q;
    inj_pos_d = inj_pos_q;
    if (is_start) begin
      inj_en_d  = inj_valid;
      inj_pos_d = inj_pos;
    end else if (page_end || violation) begin
      inj_en_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
    end else begin
      inj_en_q  <= inj_en_d;
      inj_pos_q <= inj_pos_d;
    end
  end
`else
  logic unused_inj;
  assign unused_inj = ^{inj_valid, inj_pos};
  assign flip_mask  = 16'd0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    expected_d  = expected_q;
    acc_d       = acc_q;
    out_batch_d = BATCH_IDLE;
    out_data_d  = out_data_q;
    out_code_d  = out_code_q;
    page_done_d = 1'b0;
    seq_err_d   = 1'b0;

    if (accept) begin
      out_batch_d = in_batch;
      out_data_d  = in_data ^ flip_mask;
      if (is_start) begin
        acc_d      = contrib;
        state_d    = ST_ACTIVE;
        expected_d = 3'd1;
      end else if (page_end) begin
        out_code_d  = {in_data[15], acc_q ^ contrib};
        page_done_d = 1'b1;
        state_d     = ST_IDLE;
        expected_d  = 3'd0;
      end else begin
        acc_d      = acc_q ^ contrib;
        expected_d = expected_q + 3'd1;
      end
    end else if (violation) begin
      // Drop the partial page; the next word 0 reloads the accumulator.
      seq_err_d  = 1'b1;
      state_d    = ST_IDLE;
      expected_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      expected_q  <= 3'd0;
      acc_q       <= '0;
      out_batch_q <= BATCH_IDLE;
      out_data_q  <= '0;
      out_code_q  <= '0;
      page_done_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      acc_q       <= acc_d;
      out_batch_q <= out_batch_d;
      out_data_q  <= out_data_d;
      out_code_q  <= out_code_d;
      page_done_q <= page_done_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign out_batch = out_batch_q;
  assign out_data  = out_data_q;
  assign out_code  = out_code_q;
  assign page_done = page_done_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_ecc_encoder.sv
// -----------------------------------------------------------------------------
// tb_ecc_encoder
//   Directed and randomized stimulus for ecc_encoder. Expected page codes come
//   from a bit-level reference model: each code bit is the parity of the page
//   bits whose (position + 1) has that bit set. Define ECC_ERR_INJECT_EN for
//   both bench and design to exercise error injection.
// -----------------------------------------------------------------------------
module tb_ecc_encoder;

  logic        clk;
  logic        rst;
  logic [3:0]  in_batch;
  logic [15:0] in_data;
  logic        inj_valid;
  logic [6:0]  inj_pos;
  logic [3:0]  out_batch;
  logic [15:0] out_data;
  logic [7:0]  out_code;
  logic        page_done;
  logic        seq_err;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [127:0] last_rx;

  ecc_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_batch  (in_batch),
    .in_data   (in_data),
    .inj_valid (inj_valid),
    .inj_pos   (inj_pos),
    .out_batch (out_batch),
    .out_data  (out_data),
    .out_code  (out_code),
    .page_done (page_done),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Reference model: parity per code bit over the 128-bit page.
  function automatic logic [7:0] ref_code(input logic [127:0] d);
    logic [7:0] c;
    c = '0;
    for (int k = 0; k < 7; k++)
      for (int p = 0; p < 127; p++)
        if (((p + 1) >> k) & 1) c[k] = c[k] ^ d[p];
    c[7] = d[127];
    return c;
  endfunction

  function automatic logic [127:0] rand_page();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input word, then sample 1 time unit after the active edge.
  task automatic step(input logic [3:0] b, input logic [15:0] d);
    in_batch = b;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Full back-to-back page; exp_out is the data expected on out_data.
  task automatic send_page(input string tag, input logic [127:0] pg,
                           input logic [127:0] exp_out);
    for (int b = 0; b < 8; b++) begin
      step(4'(b), pg[16*b +: 16]);
      last_rx[16*b +: 16] = out_data;
      check({tag, " out_batch"}, 16'(out_batch), 16'(b));
      check({tag, " out_data"}, out_data, exp_out[16*b +: 16]);
      check({tag, " page_done"}, 16'(page_done), 16'(b == 7));
      check({tag, " seq_err"}, 16'(seq_err), 16'd0);
      if (b == 7) check({tag, " out_code"}, 16'(out_code), 16'(ref_code(pg)));
    end
    in_batch = 4'd8;
  endtask

  initial begin
    logic [127:0] pg, pg2, fixed;
    logic [7:0]   held_code, syn;
    logic [15:0]  held_data;

    rst = 1'b1; in_batch = 4'd8; in_data = '0; inj_valid = 1'b0; inj_pos = '0;
    last_rx = '0;
    #1;
    check("reset out_batch", 16'(out_batch), 16'd8);
    check("reset out_data", out_data, 16'd0);
    check("reset out_code", 16'(out_code), 16'd0);
    check("reset page_done", 16'(page_done), 16'd0);
    check("reset seq_err", 16'(seq_err), 16'd0);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b0;

    // All-zero page.
    send_page("zero", '0, '0);

    // Single-bit pages with known codes.
    pg = '0; pg[0] = 1'b1;
    send_page("b0bit0", pg, pg);
    check("b0bit0 const", 16'(out_code), 16'h01);
    pg = '0; pg[48] = 1'b1;
    send_page("b3bit0", pg, pg);
    check("b3bit0 const", 16'(out_code), 16'h31);
    pg = '0; pg[126] = 1'b1;
    send_page("b7bit14", pg, pg);
    check("b7bit14 const", 16'(out_code), 16'h7F);
    pg = '0; pg[127] = 1'b1;
    send_page("b7bit15", pg, pg);
    check("b7bit15 const", 16'(out_code), 16'h80);

    // Random pages.
    for (int n = 0; n < 6; n++) begin
      pg = rand_page();
      send_page("rand", pg, pg);
    end

    // Code held across gaps after a page.
    held_code = ref_code(pg);
    step(4'd8, 16'hFFFF);
    check("hold out_code", 16'(out_code), 16'(held_code));
    check("hold page_done", 16'(page_done), 16'd0);

    // Gaps mid-page.
    pg = rand_page();
    step(4'd0, pg[15:0]);
    step(4'd1, pg[31:16]);
    for (int g = 0; g < 2; g++) begin
      step(4'd8, $urandom);
      check("gap out_batch", 16'(out_batch), 16'd8);
      check("gap out_data", out_data, pg[31:16]);
      check("gap seq_err", 16'(seq_err), 16'd0);
    end
    for (int b = 2; b < 8; b++) step(4'(b), pg[16*b +: 16]);
    check("gap page out_batch", 16'(out_batch), 16'd7);
    check("gap page_done", 16'(page_done), 16'd1);
    check("gap out_code", 16'(out_code), 16'(ref_code(pg)));

    // Skipped word, then out-of-order word while IDLE.
    held_code = out_code;
    pg = rand_page();
    step(4'd0, pg[15:0]);
    step(4'd1, pg[31:16]);
    step(4'd3, pg[63:48]);
    check("skip seq_err", 16'(seq_err), 16'd1);
    check("skip out_batch", 16'(out_batch), 16'd8);
    check("skip out_data", out_data, pg[31:16]);
    step(4'd4, pg[79:64]);
    check("idle4 seq_err", 16'(seq_err), 16'd1);
    check("idle4 out_batch", 16'(out_batch), 16'd8);
    step(4'd8, '0);
    check("seq_err pulse", 16'(seq_err), 16'd0);
    check("viol keeps code", 16'(out_code), 16'(held_code));
    pg = rand_page();
    send_page("after viol", pg, pg);

    // Out-of-range index in IDLE and in ACTIVE.
    step(4'd12, $urandom);
    check("idle12 seq_err", 16'(seq_err), 16'd1);
    step(4'd0, $urandom);
    held_data = out_data;
    step(4'(9 + $urandom_range(0, 6)), $urandom);
    check("act9+ seq_err", 16'(seq_err), 16'd1);
    check("act9+ out_data", out_data, held_data);

    // Restart with word 0 mid-page.
    pg2 = rand_page();
    step(4'd0, pg2[15:0]);
    step(4'd1, pg2[31:16]);
    step(4'd2, pg2[47:32]);
    pg = rand_page();
    send_page("restart", pg, pg);

    // Error injection at page bit 0x31 (word 3, bit 1).
    inj_valid = 1'b1;
    inj_pos   = 7'h31;
    pg = '0;
`ifdef ECC_ERR_INJECT_EN
    pg2 = pg; pg2[49] = ~pg2[49];
`else
    pg2 = pg;
`endif
    send_page("inject", pg, pg2);
    inj_valid = 1'b0;
    inj_pos   = '0;
    // Downstream decoder: syndrome of received data against the sent code.
    syn   = ref_code(last_rx) ^ out_code;
    fixed = last_rx;
    if (syn[6:0] != 7'd0) fixed[syn[6:0] - 7'd1] = ~fixed[syn[6:0] - 7'd1];
    check("decoder corrected w3", fixed[63:48], 16'h0000);
    check("decoder syn code7", 16'(syn[7]), 16'd0);
    send_page("post inject", '0, '0);

    // Asynchronous reset mid-page.
    pg = rand_page();
    for (int b = 0; b < 5; b++) step(4'(b), pg[16*b +: 16]);
    check("pre-rst out_batch", 16'(out_batch), 16'd4);
    #2 rst = 1'b1;
    #1;
    check("async rst out_batch", 16'(out_batch), 16'd8);
    check("async rst out_data", out_data, 16'd0);
    check("async rst out_code", 16'(out_code), 16'd0);
    check("async rst page_done", 16'(page_done), 16'd0);
    check("async rst seq_err", 16'(seq_err), 16'd0);
    #2 rst = 1'b0;
    step(4'd3, pg[63:48]);
    check("post-rst b3 seq_err", 16'(seq_err), 16'd1);
    check("post-rst b3 out_batch", 16'(out_batch), 16'd8);
    pg = rand_page();
    send_page("post-rst page", pg, pg);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
